sound_ram_arb: RTL and testbench

- Arbitrates the single-port 64 KB sound RAM between two requesters: DOC sample fetches (read-only, time-critical) and GLU host accesses (read/write).
- Sits between soundglu/es5503 and syncram, replacing the direct osc_en address mux.
- DOC has fixed priority. A bounded starvation counter guarantees GLU progress.
- Reports DOC overruns and lateness through sticky status flags.

---
 rtl/sound_pkg.sv | 22 ++
 rtl/sound_ram_arb.sv | 167 ++++++++++++++++
 tb/tb_sound_ram_arb.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound RAM arbiter.
package sound_pkg;

   localparam int SOUND_RAM_AW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef enum logic {
      OWN_DOC = 1'b0,
      OWN_GLU = 1'b1
   } owner_t;

   // Saturating 8-bit increment used by the GLU starvation counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sound_ram_arb.sv
// Single-port sound RAM arbiter: DOC fetches have priority, GLU host accesses
// are forced ahead after GLU_MAX_WAIT cycles of waiting.
module sound_ram_arb
   import sound_pkg::*;
#(
   parameter int GLU_MAX_WAIT = 8,
   parameter int ADDR_W       = SOUND_RAM_AW
)(
   input  logic              CLK_14M,
   input  logic              reset_n,
   input  logic              doc_req,
   input  logic [ADDR_W-1:0] doc_addr,
   output logic              doc_ack,
   output logic [7:0]        doc_data,
   input  logic              glu_req,
   input  logic              glu_wr,
   input  logic [ADDR_W-1:0] glu_addr,
   input  logic [7:0]        glu_wdata,
   output logic              glu_ack,
   output logic [7:0]        glu_rdata,
   output logic              glu_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              doc_overrun,
   output logic              doc_late,
   input  logic              status_clr
);

   localparam logic [7:0] MAX_WAIT = 8'(GLU_MAX_WAIT);

   state_t            state_r, state_s;
   owner_t            owner_r;
   logic              op_wr_r;
   logic              doc_pend_r, glu_pend_r;
   logic [ADDR_W-1:0] doc_addr_r, glu_addr_r;
   logic              glu_wr_r;
   logic [7:0]        glu_wdata_r;
   logic [7:0]        glu_wait_r;

   logic              doc_eff_s, glu_eff_s;
   logic [ADDR_W-1:0] doc_addr_s, glu_addr_s;
   logic              glu_wr_s;
   logic [7:0]        glu_wdata_s;
   logic              grant_doc_s, grant_glu_s;

   // Merge incoming pulses with pending requests, arbitrate, pick next state.
   always_comb begin
      doc_eff_s   = doc_pend_r | doc_req;
      doc_addr_s  = doc_req ? doc_addr : doc_addr_r;
      glu_eff_s   = glu_pend_r | glu_req;
      glu_addr_s  = glu_pend_r ? glu_addr_r  : glu_addr;
      glu_wr_s    = glu_pend_r ? glu_wr_r    : glu_wr;
      glu_wdata_s = glu_pend_r ? glu_wdata_r : glu_wdata;
      grant_doc_s = 1'b0;
      grant_glu_s = 1'b0;
      state_s     = state_r;
      case (state_r)
         IDLE, DATA: begin
            if (glu_eff_s && (!doc_eff_s || (glu_wait_r >= MAX_WAIT))) begin
               grant_glu_s = 1'b1;
            end else if (doc_eff_s) begin
               grant_doc_s = 1'b1;
            end else begin
               grant_glu_s = 1'b0;
            end
            state_s = (grant_glu_s || grant_doc_s) ? ADDR : IDLE;
         end
         ADDR:    state_s = DATA;
         default: state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK_14M or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request capture, RAM port, completion, wait counter and status flags.
   always_ff @(posedge CLK_14M or negedge reset_n) begin
      if (!reset_n) begin
         owner_r     <= OWN_DOC;
         op_wr_r     <= 1'b0;
         doc_pend_r  <= 1'b0;
         doc_addr_r  <= '0;
         glu_pend_r  <= 1'b0;
         glu_addr_r  <= '0;
         glu_wr_r    <= 1'b0;
         glu_wdata_r <= 8'h00;
         glu_wait_r  <= 8'h00;
         doc_ack     <= 1'b0;
         doc_data    <= 8'h00;
         glu_ack     <= 1'b0;
         glu_rdata   <= 8'h00;
         glu_busy    <= 1'b0;
         ram_addr    <= '0;
         ram_we      <= 1'b0;
         ram_wdata   <= 8'h00;
         doc_overrun <= 1'b0;
         doc_late    <= 1'b0;
      end else begin
         doc_ack <= 1'b0;
         glu_ack <= 1'b0;
         ram_we  <= 1'b0;

         if (state_r == DATA) begin
            if (owner_r == OWN_DOC) begin
               doc_data <= ram_rdata;
               doc_ack  <= 1'b1;
            end else begin
               glu_ack <= 1'b1;
               if (!op_wr_r) begin
                  glu_rdata <= ram_rdata;
               end
            end
         end

         if (grant_glu_s) begin
            ram_addr  <= glu_addr_s;
            ram_we    <= glu_wr_s;
            ram_wdata <= glu_wdata_s;
            owner_r   <= OWN_GLU;
            op_wr_r   <= glu_wr_s;
         end else if (grant_doc_s) begin
            ram_addr <= doc_addr_s;
            owner_r  <= OWN_DOC;
            op_wr_r  <= 1'b0;
         end

         doc_pend_r <= doc_eff_s & ~grant_doc_s;
         doc_addr_r <= doc_addr_s;
         glu_pend_r <= glu_eff_s & ~grant_glu_s;
         if (glu_req && !glu_pend_r) begin
            glu_addr_r  <= glu_addr;
            glu_wr_r    <= glu_wr;
            glu_wdata_r <= glu_wdata;
         end

         if (grant_glu_s) begin
            glu_wait_r <= 8'h00;
         end else if (glu_pend_r) begin
            glu_wait_r <= sat_inc8(glu_wait_r);
         end

         // Any GLU transaction still queued or about to reach DATA keeps busy high.
         glu_busy <= glu_eff_s | ((state_r == ADDR) && (owner_r == OWN_GLU));

         if (doc_req && doc_pend_r) begin
            doc_overrun <= 1'b1;
         end else if (status_clr) begin
            doc_overrun <= 1'b0;
         end

         if (grant_glu_s && doc_eff_s) begin
            doc_late <= 1'b1;
         end else if (status_clr) begin
            doc_late <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sound_ram_arb.sv
// Self-checking bench for sound_ram_arb: directed scenarios plus randomized
// traffic compared against a slot-level reference model.
module tb_sound_ram_arb;

   localparam int MAXW = 8;

   logic        CLK_14M = 1'b0;
   logic        reset_n;
   logic        doc_req = 1'b0;
   logic [15:0] doc_addr = 16'h0000;
   logic        doc_ack;
   logic [7:0]  doc_data;
   logic        glu_req = 1'b0;
   logic        glu_wr = 1'b0;
   logic [15:0] glu_addr = 16'h0000;
   logic [7:0]  glu_wdata = 8'h00;
   logic        glu_ack;
   logic [7:0]  glu_rdata;
   logic        glu_busy;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        doc_overrun;
   logic        doc_late;
   logic        status_clr = 1'b0;

   int checks = 0;
   int failures = 0;

   sound_ram_arb #(.GLU_MAX_WAIT(MAXW), .ADDR_W(16)) dut (
      .CLK_14M(CLK_14M), .reset_n(reset_n),
      .doc_req(doc_req), .doc_addr(doc_addr), .doc_ack(doc_ack), .doc_data(doc_data),
      .glu_req(glu_req), .glu_wr(glu_wr), .glu_addr(glu_addr), .glu_wdata(glu_wdata),
      .glu_ack(glu_ack), .glu_rdata(glu_rdata), .glu_busy(glu_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .doc_overrun(doc_overrun), .doc_late(doc_late), .status_clr(status_clr)
   );

   always #5 CLK_14M = ~CLK_14M;

   // Synchronous single-port RAM, read-before-write.
   logic [7:0] ram_mem [0:65535];
   always @(posedge CLK_14M) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // Reference model: pending requests, a two-edge access slot, shadow memory.
   logic [7:0]  m_mem [int];
   logic        m_doc_pend, m_glu_pend;
   logic [15:0] m_doc_addr, m_g_addr, m_op_addr;
   logic        m_g_wr, m_op_wr, m_op_glu;
   logic [7:0]  m_g_wd, m_op_wd, m_res;
   int          m_rem, m_wait;
   logic        exp_doc_ack, exp_glu_ack, exp_ram_we, exp_glu_busy, exp_overrun, exp_late;
   logic [7:0]  exp_doc_data, exp_glu_rdata;
   logic [15:0] exp_ram_addr;

   task automatic model_reset();
      m_doc_pend = 0; m_glu_pend = 0; m_doc_addr = 0; m_g_addr = 0; m_op_addr = 0;
      m_g_wr = 0; m_op_wr = 0; m_op_glu = 0; m_g_wd = 0; m_op_wd = 0; m_res = 0;
      m_rem = 0; m_wait = 0;
      exp_doc_ack = 0; exp_glu_ack = 0; exp_ram_we = 0; exp_glu_busy = 0;
      exp_overrun = 0; exp_late = 0; exp_doc_data = 0; exp_glu_rdata = 0; exp_ram_addr = 0;
   endtask

   task automatic model_edge();
      logic d_eff, g_eff, gg, gd, free;
      logic [15:0] d_a;
      d_eff = m_doc_pend || doc_req;
      d_a   = doc_req ? doc_addr : m_doc_addr;
      g_eff = m_glu_pend || glu_req;
      if (glu_req && !m_glu_pend) begin
         m_g_wr = glu_wr; m_g_addr = glu_addr; m_g_wd = glu_wdata;
      end
      exp_doc_ack = 0; exp_glu_ack = 0; exp_ram_we = 0;
      free = 1'b1;
      if (m_rem == 2) begin
         m_rem = 1; free = 1'b0;
         if (m_op_wr) m_mem[int'(m_op_addr)] = m_op_wd;
         else m_res = m_mem.exists(int'(m_op_addr)) ? m_mem[int'(m_op_addr)] : 8'h00;
      end else if (m_rem == 1) begin
         m_rem = 0;
         if (m_op_glu) begin
            exp_glu_ack = 1;
            if (!m_op_wr) exp_glu_rdata = m_res;
         end else begin
            exp_doc_ack = 1; exp_doc_data = m_res;
         end
      end
      gg = free && g_eff && (!d_eff || m_wait >= MAXW);
      gd = free && d_eff && !gg;
      if (doc_req && m_doc_pend) exp_overrun = 1;
      else if (status_clr) exp_overrun = 0;
      if (gg && d_eff) exp_late = 1;
      else if (status_clr) exp_late = 0;
      if (gg) m_wait = 0;
      else if (m_glu_pend && m_wait < 255) m_wait++;
      if (gg) begin
         m_op_glu = 1; m_op_wr = m_g_wr; m_op_addr = m_g_addr; m_op_wd = m_g_wd; m_rem = 2;
         exp_ram_we = m_g_wr; exp_ram_addr = m_g_addr;
      end else if (gd) begin
         m_op_glu = 0; m_op_wr = 0; m_op_addr = d_a; m_rem = 2; exp_ram_addr = d_a;
      end
      m_glu_pend = g_eff && !gg;
      m_doc_pend = d_eff && !gd;
      m_doc_addr = d_a;
      exp_glu_busy = m_glu_pend || (m_rem != 0 && m_op_glu);
   endtask

   // One clock: model follows the edge, outputs settle, one-shot inputs drop.
   task automatic tick();
      @(posedge CLK_14M);
      if (!reset_n) model_reset();
      else model_edge();
      #1;
      doc_req = 0; glu_req = 0; status_clr = 0;
   endtask

   task automatic run_until(input bit want_glu, output int lat, output int we_cnt);
      lat = -1; we_cnt = 0;
      for (int i = 0; i < 16 && lat < 0; i++) begin
         tick();
         if (ram_we === 1'b1) we_cnt++;
         if (want_glu ? (glu_ack === 1'b1) : (doc_ack === 1'b1)) lat = i;
      end
   endtask

   task automatic glu_set(input logic wr, input logic [15:0] a, input logic [7:0] d);
      glu_req = 1; glu_wr = wr; glu_addr = a; glu_wdata = d;
   endtask

   task automatic test_reset();
      reset_n = 0;
      model_reset();
      tick(); tick();
      checks++;
      if ({doc_ack, glu_ack, ram_we, glu_busy, doc_overrun, doc_late} !== 6'b000000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {doc_ack, glu_ack, ram_we, glu_busy, doc_overrun, doc_late});
      end
      checks++;
      if ({ram_addr, doc_data, glu_rdata} !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=00000000", {ram_addr, doc_data, glu_rdata});
      end
      reset_n = 1;
      tick();
   endtask

   task automatic test_glu_write_read();
      int lat, wec;
      glu_set(1'b1, 16'h0040, 8'h3C);
      run_until(1'b1, lat, wec);
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL glu_wr_latency got=%0d exp=2", lat); end
      checks++;
      if (wec !== 1) begin failures++; $display("FAIL glu_wr_we_cycles got=%0d exp=1", wec); end
      glu_set(1'b0, 16'h0040, 8'h00);
      run_until(1'b1, lat, wec);
      checks++;
      if (lat !== 2 || glu_rdata !== 8'h3C) begin
         failures++; $display("FAIL glu_rd got lat=%0d data=%h exp lat=2 data=3c", lat, glu_rdata);
      end
      checks++;
      if (wec !== 0) begin failures++; $display("FAIL glu_rd_we got=%0d exp=0", wec); end
   endtask

   task automatic test_doc_read();
      int lat, wec;
      glu_set(1'b1, 16'h1234, 8'hA5);
      run_until(1'b1, lat, wec);
      doc_req = 1; doc_addr = 16'h1234;
      run_until(1'b0, lat, wec);
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL doc_latency got=%0d exp=2", lat); end
      checks++;
      if (doc_data !== 8'hA5) begin failures++; $display("FAIL doc_data got=%h exp=a5", doc_data); end
      checks++;
      if (wec !== 0) begin failures++; $display("FAIL doc_we got=%0d exp=0", wec); end
   endtask

   task automatic test_simultaneous();
      int didx, gidx;
      didx = -1; gidx = -1;
      doc_req = 1; doc_addr = 16'h1234;
      glu_set(1'b0, 16'h0040, 8'h00);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (doc_ack === 1'b1) didx = i;
         if (glu_ack === 1'b1) gidx = i;
      end
      checks++;
      if (didx !== 2 || gidx !== 4) begin
         failures++; $display("FAIL simul_order got doc=%0d glu=%0d exp doc=2 glu=4", didx, gidx);
      end
      checks++;
      if (doc_late !== 1'b0 || doc_data !== 8'hA5 || glu_rdata !== 8'h3C) begin
         failures++;
         $display("FAIL simul_state got late=%b doc=%h glu=%h exp late=0 doc=a5 glu=3c",
                  doc_late, doc_data, glu_rdata);
      end
   endtask

   task automatic test_starvation();
      int gidx, didx, dcnt;
      gidx = -1; didx = -1; dcnt = 0;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) glu_set(1'b0, 16'h0040, 8'h00);
         if ((i % 2) == 0 && i <= 10) begin doc_req = 1; doc_addr = 16'h1234; end
         tick();
         if (glu_ack === 1'b1) gidx = i;
         if (doc_ack === 1'b1) begin dcnt++; didx = i; end
      end
      checks++;
      if (gidx !== 12) begin failures++; $display("FAIL starve_glu_ack got=%0d exp=12", gidx); end
      checks++;
      if (dcnt !== 6 || didx !== 14) begin
         failures++; $display("FAIL starve_doc got cnt=%0d last=%0d exp cnt=6 last=14", dcnt, didx);
      end
      checks++;
      if (doc_late !== 1'b1 || doc_overrun !== 1'b0) begin
         failures++; $display("FAIL starve_flags got late=%b ovr=%b exp late=1 ovr=0", doc_late, doc_overrun);
      end
      status_clr = 1;
      tick();
      checks++;
      if (doc_late !== 1'b0) begin failures++; $display("FAIL late_clear got=%b exp=0", doc_late); end
   endtask

   task automatic test_overrun();
      int lat, wec, dcnt, didx;
      glu_set(1'b1, 16'h0300, 8'h11); run_until(1'b1, lat, wec);
      glu_set(1'b1, 16'h0301, 8'h22); run_until(1'b1, lat, wec);
      dcnt = 0; didx = -1;
      glu_set(1'b0, 16'h0040, 8'h00); tick();
      doc_req = 1; doc_addr = 16'h0300; tick();
      doc_req = 1; doc_addr = 16'h0301; tick();
      checks++;
      if (doc_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", doc_overrun); end
      for (int i = 3; i < 8; i++) begin
         tick();
         if (doc_ack === 1'b1) begin dcnt++; didx = i; end
      end
      checks++;
      if (dcnt !== 1 || didx !== 4 || doc_data !== 8'h22) begin
         failures++;
         $display("FAIL overrun_fetch got cnt=%0d idx=%0d data=%h exp cnt=1 idx=4 data=22", dcnt, didx, doc_data);
      end
      status_clr = 1;
      tick();
      checks++;
      if (doc_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", doc_overrun); end
   endtask

   task automatic test_reset_mid_write();
      int lat, wec, acks;
      glu_set(1'b1, 16'h0100, 8'h77); run_until(1'b1, lat, wec);
      glu_set(1'b1, 16'h0100, 8'hEE);
      tick();
      checks++;
      if (ram_we !== 1'b1) begin failures++; $display("FAIL midrst_we_before got=%b exp=1", ram_we); end
      reset_n = 0;
      #1;
      checks++;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL midrst_we_async got=%b exp=0", ram_we); end
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (glu_ack === 1'b1) acks++;
      end
      reset_n = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (glu_ack === 1'b1) acks++;
      end
      checks++;
      if (acks !== 0 || glu_busy !== 1'b0) begin
         failures++; $display("FAIL midrst_no_ack got acks=%0d busy=%b exp acks=0 busy=0", acks, glu_busy);
      end
      glu_set(1'b0, 16'h0100, 8'h00);
      run_until(1'b1, lat, wec);
      checks++;
      if (lat !== 2 || glu_rdata !== 8'h77) begin
         failures++; $display("FAIL midrst_readback got lat=%0d data=%h exp lat=2 data=77", lat, glu_rdata);
      end
   endtask

   task automatic test_random();
      int lat, wec;
      for (int a = 0; a < 16; a++) begin
         glu_set(1'b1, 16'(a), 8'($urandom)); run_until(1'b1, lat, wec);
      end
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) == 0) begin doc_req = 1; doc_addr = 16'($urandom_range(0, 15)); end
         if (!exp_glu_busy && $urandom_range(0, 1) == 1)
            glu_set(1'($urandom), 16'($urandom_range(0, 15)), 8'($urandom));
         if ($urandom_range(0, 7) == 0) status_clr = 1;
         tick();
         checks++;
         if ({doc_ack, glu_ack, ram_we, glu_busy, doc_overrun, doc_late} !==
             {exp_doc_ack, exp_glu_ack, exp_ram_we, exp_glu_busy, exp_overrun, exp_late}) begin
            failures++;
            $display("FAIL rand_flags cyc=%0d got=%b exp=%b", i,
                     {doc_ack, glu_ack, ram_we, glu_busy, doc_overrun, doc_late},
                     {exp_doc_ack, exp_glu_ack, exp_ram_we, exp_glu_busy, exp_overrun, exp_late});
         end
         checks++;
         if ({doc_data, glu_rdata} !== {exp_doc_data, exp_glu_rdata}) begin
            failures++;
            $display("FAIL rand_data cyc=%0d got doc=%h glu=%h exp doc=%h glu=%h", i,
                     doc_data, glu_rdata, exp_doc_data, exp_glu_rdata);
         end
         checks++;
         if (ram_addr !== exp_ram_addr) begin
            failures++; $display("FAIL rand_ram_addr cyc=%0d got=%h exp=%h", i, ram_addr, exp_ram_addr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glu_write_read();
      test_doc_read();
      test_simultaneous();
      test_starvation();
      test_overrun();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
